// File: rtl/cam_pkg.sv
// Shared types and helpers for the CAM column update controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cam_pkg;

   // Update controller states: waiting for a request, writing one column
   // address per cycle, and the single completion cycle.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } cam_state_t;

   // Width of one key segment: each segment directly addresses a LUTRAM
   // column of the given depth.
   function automatic int seg_bits(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/cam_update_ctrl.sv
// CAM entry updater: rewrites every address of one entry's LUTRAM columns.
// Latency: done pulses Depth+1 cycles after acceptance; next accept at Depth+2.
// Backpressure: req_ready high only in IDLE; req_valid ignored during a sweep.
module cam_update_ctrl
   import cam_pkg::*;
#(
   parameter int Depth    = 64,
   parameter int Entries  = 32,
   parameter int Segments = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic [$clog2(Entries)-1:0]          req_entry,
   input  logic [Segments*seg_bits(Depth)-1:0] req_key,
   input  logic                                req_set,
   output logic [Entries-1:0]                  wen,
   output logic [seg_bits(Depth)-1:0]          waddr,
   output logic [Segments-1:0]                 wdin,
   output logic                                busy,
   output logic                                done
);

   localparam int AW = seg_bits(Depth);
   localparam int KW = Segments * AW;
   localparam int EW = $clog2(Entries);
   localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

   cam_state_t          state;
   logic [AW-1:0]       cnt;
   logic [KW-1:0]       key_q;
   logic                set_q;

   // A segment column stores a 1 only at the address equal to that segment
   // of the key; invalidation writes 0 everywhere.
   function automatic logic [Segments-1:0] seg_hits(input logic [KW-1:0] key,
                                                    input logic          set,
                                                    input logic [AW-1:0] addr);
      logic [Segments-1:0] h;
      h = '0;
      for (int s = 0; s < Segments; s++) begin
         h[s] = set && (key[s*AW +: AW] == addr);
      end
      return h;
   endfunction

   // One-hot column select; an index past the last entry selects nothing so
   // the sweep still runs to completion without touching any column.
   function automatic logic [Entries-1:0] entry_mask(input logic [EW-1:0] e);
      logic [Entries-1:0] m;
      m = '0;
      if ({{(32-EW){1'b0}}, e} < 32'(Entries)) begin
         m[e] = 1'b1;
      end
      return m;
   endfunction

   // The sweep address is the counter itself, so it is always registered.
   assign waddr = cnt;

   // Update FSM with all outputs registered; the first sweep address is
   // loaded on the acceptance edge so writes start the very next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         key_q     <= '0;
         set_q     <= 1'b0;
         wen       <= '0;
         wdin      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         req_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  key_q     <= req_key;
                  set_q     <= req_set;
                  cnt       <= '0;
                  wen       <= entry_mask(req_entry);
                  wdin      <= seg_hits(req_key, req_set, '0);
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  state     <= SWEEP;
               end
            end
            SWEEP: begin
               if (cnt == LastAddr) begin
                  // Last address written this cycle: stop instead of wrapping.
                  cnt   <= '0;
                  wen   <= '0;
                  wdin  <= '0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt  <= cnt + 1'b1;
                  wdin <= seg_hits(key_q, set_q, cnt + 1'b1);
               end
            end
            DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               cnt       <= '0;
               wen       <= '0;
               wdin      <= '0;
               busy      <= 1'b0;
               done      <= 1'b0;
               req_ready <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_update_ctrl.sv
// Self-checking bench for cam_update_ctrl (Depth=64, Entries=32, Segments=2).
// Latency: a time-since-acceptance model predicts every output each cycle.
// Backpressure: requests are presented and held per directed scenario.
module tb_cam_update_ctrl;

   logic        clk;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_entry = '0;
   logic [11:0] req_key = '0;
   logic        req_set = 1'b0;
   logic [31:0] wen;
   logic [5:0]  waddr;
   logic [1:0]  wdin;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;

   cam_update_ctrl #(.Depth(64), .Entries(32), .Segments(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_entry(req_entry), .req_key(req_key), .req_set(req_set),
      .wen(wen), .waddr(waddr), .wdin(wdin), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: after acceptance, k counts edges. k=0..63 writes address k,
   // k=64 is the done cycle, k>=65 is idle again.
   int          m_trst = 0;
   bit          m_act = 1'b0;
   int          m_k = 0;
   bit          m_rdy;
   logic [4:0]  m_entry = '0;
   logic [11:0] m_key = '0;
   logic        m_set = 1'b0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_trst = 0;
         m_act  = 1'b0;
         m_k    = 0;
      end else begin
         m_rdy = (m_trst >= 1) && (!m_act || m_k >= 65);
         m_trst++;
         if (m_act) m_k++;
         if (m_rdy && req_valid) begin
            m_act   = 1'b1;
            m_k     = 0;
            m_entry = req_entry;
            m_key   = req_key;
            m_set   = req_set;
         end
      end
   end

   // Every-cycle comparison against the model, on the falling edge.
   logic [31:0] e_wen;
   logic [5:0]  e_addr;
   logic [1:0]  e_wdin;
   logic        e_busy, e_done, e_rdy;

   initial forever begin
      @(negedge clk);
      e_wen = '0; e_addr = '0; e_wdin = '0; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b0;
      if (rst_n) begin
         if (m_act && m_k <= 63) begin
            e_wen  = 32'd1 << m_entry;
            e_addr = 6'(m_k);
            for (int s = 0; s < 2; s++) e_wdin[s] = m_set && (m_key[s*6 +: 6] == 6'(m_k));
            e_busy = 1'b1;
         end else if (m_act && m_k == 64) begin
            e_busy = 1'b1;
            e_done = 1'b1;
         end else begin
            e_rdy = (m_trst >= 1);
         end
      end
      chk("cyc_wen", 64'(wen), 64'(e_wen));
      chk("cyc_waddr", 64'(waddr), 64'(e_addr));
      chk("cyc_wdin", 64'(wdin), 64'(e_wdin));
      chk("cyc_busy", 64'(busy), 64'(e_busy));
      chk("cyc_done", 64'(done), 64'(e_done));
      chk("cyc_req_ready", 64'(req_ready), 64'(e_rdy));
   end

   // Acceptance monitor: records the edge number of each observed handshake.
   int cyc = 0;
   bit rv;
   int acc_q[$];
   initial forever begin
      @(negedge clk);
      rv = rst_n && req_ready && req_valid;
      @(posedge clk);
      cyc++;
      if (rv && rst_n) acc_q.push_back(cyc);
   end

   // Wait for req_ready, present a request, return one step after acceptance.
   task automatic send(input logic [4:0] e, input logic [11:0] key, input logic s, input bit hold);
      int n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("send_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_entry = e;
      req_key   = key;
      req_set   = s;
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
   endtask

   // Observe cycles 1..66 after acceptance (cycle 1 = current step).
   int cap_wen, cap_h0, cap_a0, cap_h1, cap_a1, cap_gaps, cap_dcnt, cap_dcyc, cap_other;
   task automatic capture(input logic [31:0] mask, input logic [31:0] other);
      int prev = -1;
      cap_wen = 0; cap_h0 = 0; cap_a0 = -1; cap_h1 = 0; cap_a1 = -1;
      cap_gaps = 0; cap_dcnt = 0; cap_dcyc = 0; cap_other = 0;
      for (int c = 1; c <= 66; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         if (wen == mask) begin
            cap_wen++;
            if (prev >= 0 && int'(waddr) != prev + 1) cap_gaps++;
            prev = int'(waddr);
         end
         if (wen == other) cap_other++;
         if (wdin[0]) begin cap_h0++; cap_a0 = int'(waddr); end
         if (wdin[1]) begin cap_h1++; cap_a1 = int'(waddr); end
         if (done) begin cap_dcnt++; cap_dcyc = c; end
      end
   endtask

   int n0, n;

   initial begin
      // Reset: everything held at zero, req_ready rises one edge after release.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wen", 64'(wen), 64'd0);
      chk("rst_waddr", 64'(waddr), 64'd0);
      chk("rst_wdin", 64'(wdin), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      rst_n = 1'b1;
      chk("rel_ready_before_edge", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      chk("rel_ready_after_edge", 64'(req_ready), 64'd1);

      // Entry 5, key 0x3A7: segment0 = 0x27, segment1 = 0x0E.
      send(5'd5, 12'h3A7, 1'b1, 1'b0);
      capture(32'h0000_0020, 32'hFFFF_FFFF);
      chk("a_wen_cycles", 64'(cap_wen), 64'd64);
      chk("a_seg0_hits", 64'(cap_h0), 64'd1);
      chk("a_seg0_addr", 64'(cap_a0), 64'h27);
      chk("a_seg1_hits", 64'(cap_h1), 64'd1);
      chk("a_seg1_addr", 64'(cap_a1), 64'h0E);
      chk("a_gaps", 64'(cap_gaps), 64'd0);
      chk("a_done_count", 64'(cap_dcnt), 64'd1);
      chk("a_done_cycle", 64'(cap_dcyc), 64'd65);

      // Entry 31 invalidate: all-zero data across 64 writes.
      send(5'd31, 12'hFFF, 1'b0, 1'b0);
      capture(32'h8000_0000, 32'hFFFF_FFFF);
      chk("b_wen_cycles", 64'(cap_wen), 64'd64);
      chk("b_wdin_ones", 64'(cap_h0 + cap_h1), 64'd0);
      chk("b_done_count", 64'(cap_dcnt), 64'd1);
      chk("b_done_cycle", 64'(cap_dcyc), 64'd65);

      // req_valid held high across three requests.
      n0 = acc_q.size();
      send(5'd3, 12'h041, 1'b1, 1'b1);
      req_entry = 5'd9; req_key = 12'hABC;
      capture(32'h0000_0008, 32'h0000_0200);
      chk("c1_wen_cycles", 64'(cap_wen), 64'd64);
      chk("c1_no_overlap", 64'(cap_other), 64'd0);
      chk("c1_seg0_addr", 64'(cap_a0), 64'h01);
      chk("c1_seg1_addr", 64'(cap_a1), 64'h01);
      chk("c1_gaps", 64'(cap_gaps), 64'd0);
      @(posedge clk); #1;
      req_entry = 5'd17; req_key = 12'h000;
      capture(32'h0000_0200, 32'h0002_0000);
      chk("c2_wen_cycles", 64'(cap_wen), 64'd64);
      chk("c2_no_overlap", 64'(cap_other), 64'd0);
      chk("c2_seg0_addr", 64'(cap_a0), 64'h3C);
      chk("c2_seg1_addr", 64'(cap_a1), 64'h2A);
      chk("c2_gaps", 64'(cap_gaps), 64'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      capture(32'h0002_0000, 32'h0000_0200);
      chk("c3_wen_cycles", 64'(cap_wen), 64'd64);
      chk("c3_done_count", 64'(cap_dcnt), 64'd1);
      chk("c3_gaps", 64'(cap_gaps), 64'd0);
      chk("c_accept_count", 64'(acc_q.size() - n0), 64'd3);
      if (acc_q.size() >= n0 + 3) begin
         chk("c_spacing_1", 64'(acc_q[n0+1] - acc_q[n0]), 64'd66);
         chk("c_spacing_2", 64'(acc_q[n0+2] - acc_q[n0+1]), 64'd66);
      end

      // Reset in the middle of a sweep at address 20.
      send(5'd7, 12'h5C3, 1'b1, 1'b0);
      n = 0;
      while (waddr != 6'd20 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("d_reached_addr20", 64'(waddr), 64'd20);
      chk("d_wen_before", 64'(wen), 64'h80);
      #2;
      rst_n = 1'b0;
      #1;
      chk("d_wen_cleared", 64'(wen), 64'd0);
      chk("d_busy_cleared", 64'(busy), 64'd0);
      chk("d_waddr_cleared", 64'(waddr), 64'd0);
      chk("d_ready_in_reset", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("d_ready_after", 64'(req_ready), 64'd1);
      chk("d_wen_after", 64'(wen), 64'd0);
      chk("d_busy_after", 64'(busy), 64'd0);

      // Reissue after the aborted sweep completes normally.
      send(5'd7, 12'h5C3, 1'b1, 1'b0);
      capture(32'h0000_0080, 32'hFFFF_FFFF);
      chk("e_wen_cycles", 64'(cap_wen), 64'd64);
      chk("e_seg0_addr", 64'(cap_a0), 64'h03);
      chk("e_seg1_addr", 64'(cap_a1), 64'h17);
      chk("e_done_cycle", 64'(cap_dcyc), 64'd65);

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog got=timeout expected=finish at t=%0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
